// File: rtl/k580_crtdma.sv
// k580_crtdma: single-channel DMA sequencer feeding k580vg75 row buffers.
// Define K580_CRTDMA_AUTOLOAD_EN to implement mode bit1 (autoload at TC).
module k580_crtdma #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic [1:0]        iaddr,
    input  logic [7:0]        idata,
    output logic [7:0]        odata,
    input  logic              iwe_n,
    input  logic              ird_n,
    input  logic              drq,
    output logic              dack,
    output logic              hrq,
    input  logic              hlda,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              tc
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_S1,
        ST_S2,
        ST_S3
    } state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_base_addr;
    logic [ADDR_W-1:0]  r_cur_addr;
    logic [CNT_W-1:0]   r_base_cnt;
    logic [CNT_W-1:0]   r_cur_cnt;
    logic               r_en;
    logic               r_auto;
    logic               r_ff;
    logic               r_we_d;
    logic               r_rd_d;

    logic               w_wr;
    logic               w_rd_rise;
    logic               w_auto_bit;
    logic               w_busy;
    logic               w_tc_hit;
    logic               w_reload;
    logic               w_en_next;
    logic               w_cont;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [15:0]        w_ba16;
    logic [15:0]        w_ca16;
    logic [15:0]        w_bc16;
    logic [15:0]        w_cc16;
    logic [7:0]         w_rdata;

`ifdef K580_CRTDMA_AUTOLOAD_EN
    assign w_auto_bit = idata[1];
`else
    assign w_auto_bit = 1'b0;
`endif

    assign w_wr      = r_we_d & ~iwe_n;
    assign w_rd_rise = ~r_rd_d & ird_n;
    assign w_busy    = (r_state != ST_IDLE);

    // End-of-transfer bookkeeping: TC detection, autoload and next pointers
    always_comb begin
        w_tc_hit    = (r_cur_cnt == '0);
        w_reload    = w_tc_hit & r_auto;
        w_addr_next = w_reload ? r_base_addr : r_cur_addr + ADDR_W'(1);
        w_cnt_next  = w_reload ? r_base_cnt : r_cur_cnt - CNT_W'(1);
        w_en_next   = r_en & ~(w_tc_hit & ~r_auto);
        w_cont      = drq & w_en_next & hlda;
    end

    // Byte-lane merge of CPU write data into base and current registers
    always_comb begin
        w_ba16 = 16'(r_base_addr);
        w_ca16 = 16'(r_cur_addr);
        w_bc16 = 16'(r_base_cnt);
        w_cc16 = 16'(r_cur_cnt);
        if (r_ff) begin
            w_ba16[15:8] = idata;
            w_ca16[15:8] = idata;
            w_bc16[15:8] = idata;
            w_cc16[15:8] = idata;
        end else begin
            w_ba16[7:0] = idata;
            w_ca16[7:0] = idata;
            w_bc16[7:0] = idata;
            w_cc16[7:0] = idata;
        end
    end

    // CPU read data selection
    always_comb begin
        w_rdata = 8'h00;
        unique case (iaddr)
            2'd0:    w_rdata = r_cur_addr[7:0];
            2'd1:    w_rdata = r_cur_cnt[7:0];
            2'd2:    w_rdata = {6'b0, r_auto, r_en};
            default: w_rdata = {w_busy, 5'b0, r_auto, r_tc_q()};
        endcase
    end

    function automatic logic r_tc_q();
        return tc;
    endfunction

    // Strobe edge detectors for CPU write and read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_d <= 1'b1;
            r_rd_d <= 1'b1;
        end else begin
            r_we_d <= iwe_n;
            r_rd_d <= ird_n;
        end
    end

    // Registered CPU read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            odata <= 8'h00;
        end else begin
            odata <= w_rdata;
        end
    end

    // Transfer sequencer and programming registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_base_addr <= '0;
            r_cur_addr  <= '0;
            r_base_cnt  <= '0;
            r_cur_cnt   <= '0;
            r_en        <= 1'b0;
            r_auto      <= 1'b0;
            r_ff        <= 1'b0;
            hrq         <= 1'b0;
            dack        <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            tc          <= 1'b0;
        end else begin
            if (w_rd_rise && iaddr == 2'd3) begin
                tc <= 1'b0;
            end
            if (ce) begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (r_en && drq) begin
                            r_state <= ST_REQ;
                            hrq     <= 1'b1;
                        end
                    end
                    ST_REQ: begin
                        if (!r_en) begin
                            r_state <= ST_IDLE;
                            hrq     <= 1'b0;
                        end else if (hlda) begin
                            r_state  <= ST_S1;
                            mem_rd   <= 1'b1;
                            mem_addr <= r_cur_addr;
                        end
                    end
                    ST_S1: begin
                        r_state <= ST_S2;
                        dack    <= 1'b1;
                    end
                    ST_S2: begin
                        r_state <= ST_S3;
                        dack    <= 1'b0;
                        mem_rd  <= 1'b0;
                    end
                    ST_S3: begin
                        r_cur_addr <= w_addr_next;
                        r_cur_cnt  <= w_cnt_next;
                        r_en       <= w_en_next;
                        if (w_tc_hit) begin
                            tc <= 1'b1;
                        end
                        if (w_cont) begin
                            r_state  <= ST_S1;
                            mem_rd   <= 1'b1;
                            mem_addr <= w_addr_next;
                        end else begin
                            r_state <= ST_IDLE;
                            hrq     <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        hrq     <= 1'b0;
                        dack    <= 1'b0;
                        mem_rd  <= 1'b0;
                    end
                endcase
            end
            if (w_wr) begin
                unique case (iaddr)
                    2'd0: begin
                        r_base_addr <= ADDR_W'(w_ba16);
                        if (!r_en) begin
                            r_cur_addr <= ADDR_W'(w_ca16);
                        end
                        r_ff <= ~r_ff;
                    end
                    2'd1: begin
                        r_base_cnt <= CNT_W'(w_bc16);
                        if (!r_en) begin
                            r_cur_cnt <= CNT_W'(w_cc16);
                        end
                        r_ff <= ~r_ff;
                    end
                    2'd2: begin
                        r_en   <= idata[0];
                        r_auto <= w_auto_bit;
                        r_ff   <= 1'b0;
                        if (idata[0]) begin
                            r_cur_addr <= r_base_addr;
                            r_cur_cnt  <= r_base_cnt;
                            tc         <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/k580_crtdma.md
# k580_crtdma

Single-channel DMA sequencer that feeds the k580vg75 CRT controller's row buffers from video RAM. It requests the CPU bus with a HOLD/HLDA handshake and performs read-and-strobe cycles into the CRT's `dack` input whenever `drq` is raised. It tracks address and terminal count, with optional autoload for frame-periodic refresh. It sits between the CPU bus, video RAM and k580vg75, and is programmed by the CPU through a 4-register port.

## Interface
- `ADDR_W`, 16: memory address width.
- `CNT_W`, 14: transfer count width; a programmed value N performs N+1 transfers.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ce` in 1: DMA step enable; the state machine advances only when `ce`=1.
- `iaddr` in 2: register select. 0 = address, 1 = count, 2 = mode, 3 = status.
- `idata` in 8: CPU write data.
- `odata` out 8: CPU read data.
- `iwe_n` in 1: write strobe. Acts on the falling edge, sampled in `clk`.
- `ird_n` in 1: read strobe. Side effects occur on the rising edge.
- `drq` in 1: request from the CRT controller.
- `dack` out 1: data strobe to the CRT. The CRT latches bus data on the rising edge of `dack`.
- `hrq` out 1: bus hold request to the CPU.
- `hlda` in 1: hold acknowledge from the CPU.
- `mem_addr` out ADDR_W: video RAM read address.
- `mem_rd` out 1: memory read enable.
- `tc` out 1: terminal-count flag, sticky.

## Operation
- Registers:
  - Address and count are written as 2 bytes each, low byte first, selected by a shared byte flip-flop.
  - The flip-flop toggles on every address or count write. It is cleared by any mode write and by reset.
  - Each write loads the base register. While the channel is disabled, the same write also loads the current register.
- Mode register:
  - bit0 = enable.
  - bit1 = autoload.
  - Writing enable=1 copies base into current and clears `tc`.
- Status read (`iaddr`=3): `odata` = {busy, 5'b0, autoload, tc}. The rising edge of `ird_n` on a status read clears `tc`.
- Other reads (`iaddr`=0..2): return the low byte of current address, low byte of current count, and the mode register respectively.
- State machine (all transitions on `ce`):
  - IDLE: if enable && `drq`, go to REQ.
  - REQ: `hrq`=1. Wait for `hlda`=1, then go to S1.
  - S1: `mem_addr`=current address, `mem_rd`=1.
  - S2: `mem_rd`=1, `dack`=1.
  - S3: `dack`=0 and `mem_rd`=0. Address increments; count decrements.
    - If the count was 0 before the decrement: set `tc`. With autoload, reload current from base; without it, clear enable.
    - Then go to S1 if `drq` && enable && `hlda`. Otherwise go to IDLE, dropping `hrq` in the same step.
- Address wraps at 2^ADDR_W. A count of 0 performs exactly one transfer.
- Mid-operation events:
  - Enable cleared or `hlda` dropped during S1/S2: the current transfer completes through S3, then the block releases the bus.
  - `drq` falling during S1/S2: same, the transfer completes.
  - Register write during S3 that coincides with an autoload reload: the reload uses the base value from before the write.

## Timing
- Reset values:
  - `hrq`, `dack`, `mem_rd`, `tc` = 0; `mem_addr` = 0; `odata` = 0.
  - Mode = 0; all address and count registers = 0; byte flip-flop = 0; state = IDLE.
- Latency:
  - `drq` to `hrq`: 1 `ce` tick.
  - `hlda` to the first `mem_rd`: 1 `ce` tick.
  - Each transfer takes 3 `ce` ticks. `mem_addr` is stable from S1 through S3.
- Data timing: `mem_rd` leads `dack` by one tick, so read data is valid at the rising edge of `dack`.
- `hrq` is deasserted on the same tick the block enters IDLE.
- All outputs are registered.

## Configuration
- `K580_CRTDMA_AUTOLOAD_EN` defined:
  - mode bit1 is implemented.
  - At TC with autoload set, current is reloaded from base and the channel stays enabled.
- Not defined:
  - mode bit1 is ignored and reads back 0.
  - The base registers are still present for write-through.
  - TC always clears enable.

## Test plan
- Program address 0x76D0, count 3, mode 0x01; hold `drq`=1 with `hlda` tied to `hrq` delayed 1 tick -> 4 `dack` pulses at addresses 0x76D0..0x76D3; `tc`=1; enable=0; `hrq` falls after the 4th S3.
- Same setup with mode 0x03 and autoload enabled -> after 4 transfers, current address reads 0xD0 again, `tc`=1, and the channel remains enabled; a status read clears `tc`.
- Pulse `drq` for 1 tick only -> exactly one transfer, then IDLE with `hrq`=0.
- Drop `hlda` during S1 -> that transfer completes with a `dack` pulse, no second transfer, `hrq`=0.
- Address 0xFFFF, count 1 -> transfers at 0xFFFF then 0x0000.
- Assert `rst_n`=0 during S2 -> `dack`, `hrq`, `mem_rd`, `tc` go to 0 immediately; mode reads 0.
